// File: rtl/lru_tracker_pkg.sv
// Shared types and helpers for the move-to-front LRU tracker.
package lru_tracker_pkg;

  // Upper bounds for the result bundle; real widths are sliced out in the top.
  localparam int unsigned LruMaxIdxW  = 16;
  localparam int unsigned LruMaxDataW = 64;

  // Index width for a given depth; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Per-lookup outcome registered for one cycle.
  typedef struct packed {
    logic                   hit;
    logic [LruMaxIdxW-1:0]  idx;
    logic                   evict_valid;
    logic [LruMaxDataW-1:0] evict_data;
  } lru_result_t;

endpackage

// File: rtl/lru_match_unit.sv
// Combinational lookup: lowest matching valid slot and the shift mask it implies.
module lru_match_unit
  import lru_tracker_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned IDX_W  = idx_w(DEPTH)
) (
  input  logic [DATA_W-1:0]       data_i,
  input  logic [DEPTH*DATA_W-1:0] buf_data_i,
  input  logic [DEPTH-1:0]        buf_valid_i,
  output logic                    hit_o,
  output logic [IDX_W-1:0]        k_o,
  output logic [DEPTH-1:0]        shift_mask_o
);

  logic [DEPTH-1:0] onehot;

  // Scan from the top down so the lowest matching slot wins.
  always_comb begin
    hit_o = 1'b0;
    k_o   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (buf_valid_i[i] && (buf_data_i[i*DATA_W +: DATA_W] == data_i)) begin
        hit_o = 1'b1;
        k_o   = IDX_W'(unsigned'(i));
      end
    end
  end

  // Slots 0..k move on a hit; every slot moves on a miss.
  always_comb begin
    onehot       = DEPTH'(1) << k_o;
    shift_mask_o = hit_o ? (onehot | (onehot - DEPTH'(1))) : '1;
  end

endmodule

// File: rtl/lru_tracker.sv
// Move-to-front buffer of the DEPTH most recent distinct values.
// Optional hit/miss counters are built when LRU_TRACKER_STATS_EN is defined.
module lru_tracker
  import lru_tracker_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned IDX_W = idx_w(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk_in,
  input  logic                    reset_n_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    flush_in,
  output logic                    res_valid,
  output logic                    res_hit,
  output logic [IDX_W-1:0]        res_idx,
  output logic                    evict_valid,
  output logic [DATA_W-1:0]       evict_data,
  output logic [DEPTH*DATA_W-1:0] buf_data,
  output logic [DEPTH-1:0]        buf_valid,
  output logic [CNT_W-1:0]        occupancy
`ifdef LRU_TRACKER_STATS_EN
  ,
  input  logic                    stats_clr_in,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
`endif
);

  logic                    s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]       s1_data_q, s1_data_d;
  logic [DEPTH*DATA_W-1:0] buf_data_q, buf_data_d;
  logic [DEPTH-1:0]        buf_valid_q, buf_valid_d;
  logic [CNT_W-1:0]        occupancy_q, occupancy_d;
  logic                    res_valid_q, res_valid_d;
  lru_result_t             res_q, res_d;

  logic                    hit;
  logic [IDX_W-1:0]        k;
  logic [DEPTH-1:0]        shift_mask;
  logic                    result_fire;

  assign in_ready    = !flush_in;
  // A flush swallows whatever is in stage 1.
  assign result_fire = s1_valid_q && !flush_in;

  lru_match_unit #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_match (
    .data_i       (s1_data_q),
    .buf_data_i   (buf_data_q),
    .buf_valid_i  (buf_valid_q),
    .hit_o        (hit),
    .k_o          (k),
    .shift_mask_o (shift_mask)
  );

  // Next-state for stage 1, the buffer, occupancy and the result bundle.
  always_comb begin
    s1_valid_d  = in_valid && in_ready;
    s1_data_d   = (in_valid && in_ready) ? data_in : s1_data_q;
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
    occupancy_d = occupancy_q;
    res_valid_d = 1'b0;
    res_d       = '0;

    if (flush_in) begin
      // Contents are left in place; only the valid bits drop.
      buf_valid_d = '0;
      occupancy_d = '0;
    end else if (s1_valid_q) begin
      buf_data_d[DATA_W-1:0] = s1_data_q;
      buf_valid_d[0]         = 1'b1;
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (shift_mask[i]) begin
          buf_data_d[i*DATA_W +: DATA_W] = buf_data_q[(i-1)*DATA_W +: DATA_W];
          buf_valid_d[i]                 = buf_valid_q[i-1];
        end
      end

      res_valid_d = 1'b1;
      res_d.hit   = hit;
      res_d.idx   = hit ? LruMaxIdxW'(k) : '0;
      if (!hit) begin
        if (buf_valid_q[DEPTH-1]) begin
          res_d.evict_valid = 1'b1;
          res_d.evict_data  = LruMaxDataW'(buf_data_q[(DEPTH-1)*DATA_W +: DATA_W]);
        end else begin
          occupancy_d = occupancy_q + CNT_W'(1);
        end
      end
    end
  end

  // All tracker state, cleared asynchronously.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      buf_data_q  <= '0;
      buf_valid_q <= '0;
      occupancy_q <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
      occupancy_q <= occupancy_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_hit     = res_q.hit;
  assign res_idx     = res_q.idx[IDX_W-1:0];
  assign evict_valid = res_q.evict_valid;
  assign evict_data  = res_q.evict_data[DATA_W-1:0];
  assign buf_data    = buf_data_q;
  assign buf_valid   = buf_valid_q;
  assign occupancy   = occupancy_q;

  // Padding bits of the result bundle are constant zero and intentionally unread.
  logic unused_res_bits;
  assign unused_res_bits = ^res_q;

`ifdef LRU_TRACKER_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Saturating hit/miss counters; flush does not touch them.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (stats_clr_in) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (result_fire) begin
      if (hit) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_lru_tracker.sv
// Bench for lru_tracker (DATA_W=8, DEPTH=4): directed scenarios plus random traffic
// checked against a queue-based move-to-front model.
module tb_lru_tracker;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic                    clk_in = 1'b0;
  logic                    reset_n_in;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       data_in;
  logic                    flush_in;
  logic                    res_valid;
  logic                    res_hit;
  logic [1:0]              res_idx;
  logic                    evict_valid;
  logic [DATA_W-1:0]       evict_data;
  logic [DEPTH*DATA_W-1:0] buf_data;
  logic [DEPTH-1:0]        buf_valid;
  logic [2:0]              occupancy;
`ifdef LRU_TRACKER_STATS_EN
  logic                    stats_clr_in;
  logic [31:0]             hit_cnt;
  logic [31:0]             miss_cnt;
`endif

  always #5 clk_in = ~clk_in;

  lru_tracker #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_in      (clk_in),
    .reset_n_in  (reset_n_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .flush_in    (flush_in),
    .res_valid   (res_valid),
    .res_hit     (res_hit),
    .res_idx     (res_idx),
    .evict_valid (evict_valid),
    .evict_data  (evict_data),
    .buf_data    (buf_data),
    .buf_valid   (buf_valid),
    .occupancy   (occupancy)
`ifdef LRU_TRACKER_STATS_EN
    ,
    .stats_clr_in (stats_clr_in),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: q[0] is most recent; pending_* is the value in stage 1.
  logic [DATA_W-1:0] q[$];
  logic              pend_v;
  logic [DATA_W-1:0] pend_d;
  logic              exp_rv, exp_hit, exp_ev;
  int                exp_idx;
  logic [DATA_W-1:0] exp_ed;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic v, input logic [DATA_W-1:0] d, input logic f);
    int pos;
    pos     = -1;
    exp_rv  = 1'b0;
    exp_hit = 1'b0;
    exp_ev  = 1'b0;
    exp_idx = 0;
    exp_ed  = '0;
    if (f) begin
      q.delete();
    end else if (pend_v) begin
      foreach (q[i]) if (pos < 0 && q[i] == pend_d) pos = i;
      exp_rv = 1'b1;
      if (pos >= 0) begin
        exp_hit = 1'b1;
        exp_idx = pos;
        q.delete(pos);
      end else if (q.size() == DEPTH) begin
        exp_ev = 1'b1;
        exp_ed = q[DEPTH-1];
        void'(q.pop_back());
      end
      q.push_front(pend_d);
    end
    pend_v = v && !f;
    pend_d = d;
  endtask

  task automatic compare_all();
    check("res_valid", res_valid, exp_rv);
    if (exp_rv) begin
      check("res_hit", res_hit, exp_hit);
      check("res_idx", res_idx, exp_idx);
    end
    check("evict_valid", evict_valid, exp_ev);
    if (exp_ev) check("evict_data", evict_data, exp_ed);
    check("occupancy", occupancy, q.size());
    check("buf_valid", buf_valid, (64'd1 << q.size()) - 64'd1);
    foreach (q[i]) check($sformatf("buf_data[%0d]", i), buf_data[i*DATA_W +: DATA_W], q[i]);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " res_valid"}, res_valid, 0);
    check({tag, " res_hit"}, res_hit, 0);
    check({tag, " res_idx"}, res_idx, 0);
    check({tag, " evict_valid"}, evict_valid, 0);
    check({tag, " evict_data"}, evict_data, 0);
    check({tag, " buf_valid"}, buf_valid, 0);
    check({tag, " buf_data"}, buf_data, 0);
    check({tag, " occupancy"}, occupancy, 0);
  endtask

  // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic f);
    @(negedge clk_in);
    in_valid = v;
    data_in  = d;
    flush_in = f;
    #1;
    check("in_ready", in_ready, !f);
    @(posedge clk_in);
    model_edge(v, d, f);
    #1;
    compare_all();
  endtask

  localparam logic [7:0] A = 8'hA1, B = 8'hB2, C = 8'hC3, D = 8'hD4, E = 8'hE5, X = 8'h5A;

  initial begin
    reset_n_in = 1'b0;
    in_valid   = 1'b0;
    data_in    = '0;
    flush_in   = 1'b0;
    pend_v     = 1'b0;
    pend_d     = '0;
`ifdef LRU_TRACKER_STATS_EN
    stats_clr_in = 1'b0;
`endif
    #22;
    check_reset_state("reset");
    @(negedge clk_in);
    reset_n_in = 1'b1;

    // Fill with four distinct values.
    step(1, A, 0);
    step(1, B, 0);
    step(1, C, 0);
    step(1, D, 0);
    step(0, 0, 0);
    check("fill buf_data", buf_data, {A, B, C, D});
    check("fill occupancy", occupancy, 4);

    // E evicts A.
    step(1, E, 0);
    step(1, C, 0);
    check("E evict_valid", evict_valid, 1);
    check("E evict_data", evict_data, A);

    // C hits at slot 2.
    step(1, C, 0);
    check("C hit", res_hit, 1);
    check("C idx", res_idx, 2);
    check("C buf_data", buf_data, {B, D, E, C});

    // Repeated C hits at slot 0 with the buffer untouched.
    step(1, X, 0);
    check("C2 idx", res_idx, 0);
    check("C2 buf_data", buf_data, {B, D, E, C});
`ifdef LRU_TRACKER_STATS_EN
    check("hit_cnt", hit_cnt, 2);
    check("miss_cnt", miss_cnt, 5);
    stats_clr_in = 1'b1;
`endif

    // Flush drops X in stage 1.
    step(0, 0, 1);
    check("flush buf_valid", buf_valid, 0);
    check("flush res_valid", res_valid, 0);
`ifdef LRU_TRACKER_STATS_EN
    stats_clr_in = 1'b0;
    check("clr hit_cnt", hit_cnt, 0);
    check("clr miss_cnt", miss_cnt, 0);
`endif
    step(1, X, 0);
    step(0, 0, 0);
    check("X miss", res_hit, 0);
    check("X occupancy", occupancy, 1);

    // Random traffic over a small value range so hits and evictions both occur.
    for (int n = 0; n < 120; n++) begin
      step(($urandom_range(0, 9) != 0), DATA_W'($urandom_range(0, 6)),
           ($urandom_range(0, 24) == 0));
    end

    // Asynchronous reset mid-stream.
    @(negedge clk_in);
    in_valid = 1'b1;
    data_in  = 8'h03;
    #2;
    reset_n_in = 1'b0;
    #1;
    check_reset_state("async reset");
    q.delete();
    pend_v = 1'b0;
    @(posedge clk_in);
    #1;
    check_reset_state("held reset");
    @(negedge clk_in);
    in_valid   = 1'b0;
    reset_n_in = 1'b1;

    for (int n = 0; n < 80; n++) begin
      step(($urandom_range(0, 4) != 0), DATA_W'($urandom_range(0, 5)),
           ($urandom_range(0, 30) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
